// File: rtl/joystick_direction_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// joystick_direction_ctrl_pkg
// Shared direction/request encoding for the joystick front end and game_logic.
//   dirT : 2-bit committed direction (UP=0, RIGHT=1, DOWN=2, LEFT=3)
//   reqT : 3-bit request, either {1'b0, dir} or REQ_NONE (3'b100)
// Axis comparator pairs are read as {one, two}.
// -----------------------------------------------------------------------------
package joystick_direction_ctrl_pkg;

    typedef logic [1:0] dirT;
    typedef logic [2:0] reqT;

    localparam dirT DIR_UP    = 2'd0;
    localparam dirT DIR_RIGHT = 2'd1;
    localparam dirT DIR_DOWN  = 2'd2;
    localparam dirT DIR_LEFT  = 2'd3;

    localparam reqT REQ_NONE  = 3'b100;

    // Comparator pair patterns, {one, two}; 2'b01 is invalid and reads as centre.
    localparam logic [1:0] AXIS_NEG    = 2'b00;
    localparam logic [1:0] AXIS_CENTRE = 2'b10;
    localparam logic [1:0] AXIS_POS    = 2'b11;

    // Opposite directions differ only in the upper bit.
    function automatic dirT reverseDir(input dirT d);
        return d ^ 2'b10;
    endfunction

    // RIGHT and LEFT are the odd codes.
    function automatic logic isHorizontal(input dirT d);
        return d[0];
    endfunction

    function automatic reqT dirReq(input dirT d);
        return {1'b0, d};
    endfunction

endpackage

// File: rtl/joystick_direction_ctrl_debounce.sv
// -----------------------------------------------------------------------------
// joystick_direction_ctrl_debounce
// Two-stage synchroniser for the asynchronous comparator inputs plus a
// stability filter for the decoded request.
//   clk, reset      : clock, synchronous active-high reset
//   asyncIn         : raw comparator bits (SYNC_W wide)
//   syncOut         : asyncIn after two flops
//   rawReq          : decoded request from the parent (REQ_W wide)
//   stableReq       : request that has been constant for DEBOUNCE_CYCLES cycles
//   stableChanged   : 1-cycle strobe, high in the cycle stableReq takes a new value
// -----------------------------------------------------------------------------
module joystick_direction_ctrl_debounce #(
    parameter int                 SYNC_W          = 4,
    parameter logic [SYNC_W-1:0]  SYNC_INIT       = '0,
    parameter int                 REQ_W           = 3,
    parameter logic [REQ_W-1:0]   REQ_INIT        = '0,
    parameter int                 DEBOUNCE_CYCLES = 250000,
    parameter int                 CNT_W           = 18
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [SYNC_W-1:0] asyncIn,
    output logic [SYNC_W-1:0] syncOut,
    input  logic [REQ_W-1:0]  rawReq,
    output logic [REQ_W-1:0]  stableReq,
    output logic              stableChanged
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_W-1:0] syncMeta;
    logic [SYNC_W-1:0] syncStage;
    logic [REQ_W-1:0]  prevReq;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cntNext;
    logic              load;

    assign syncOut = syncStage;

    // NOTE: every signal assigned in always_comb gets a default first, otherwise
    // a path that skips the assignment infers a latch.
    always_comb begin
        cntNext = cnt;
        if (rawReq != prevReq) begin
            cntNext = '0;
        end else if (cnt != CNT_MAX) begin
            cntNext = cnt + 1'b1;
        end
    end

    // stableReq is (re)loaded in the same edge the counter reaches its ceiling.
    assign load = (cntNext == CNT_MAX);

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            syncMeta      <= SYNC_INIT;
            syncStage     <= SYNC_INIT;
            prevReq       <= REQ_INIT;
            cnt           <= '0;
            stableReq     <= REQ_INIT;
            stableChanged <= 1'b0;
        end else begin
            syncMeta      <= asyncIn;
            syncStage     <= syncMeta;
            prevReq       <= rawReq;
            cnt           <= cntNext;
            stableChanged <= load && (rawReq != stableReq);
            if (load) begin
                stableReq <= rawReq;
            end
        end
    end

endmodule

// File: rtl/joystick_direction_ctrl.sv
// -----------------------------------------------------------------------------
// joystick_direction_ctrl
// Turns four joystick threshold comparators into a debounced, reversal-safe
// snake direction. One turn is held pending and committed on move_tick.
//   clk          : pixel clock
//   reset        : synchronous active-high reset
//   res_x_one/two: X low/high threshold comparators (async)
//   res_y_one/two: Y low/high threshold comparators (async)
//   move_tick    : 1-cycle step pulse from game_logic, consumes the pending turn
//   direction    : committed direction (UP=0, RIGHT=1, DOWN=2, LEFT=3)
//   dir_pending  : a legal turn is waiting for the next move_tick
//   dir_changed  : 1-cycle pulse in the cycle direction takes a new value
// -----------------------------------------------------------------------------
module joystick_direction_ctrl
    import joystick_direction_ctrl_pkg::*;
#(
    parameter int  DEBOUNCE_CYCLES = 250000,
    parameter int  CNT_W           = 18,
    parameter dirT INIT_DIR        = DIR_RIGHT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       res_x_one,
    input  logic       res_x_two,
    input  logic       res_y_one,
    input  logic       res_y_two,
    input  logic       move_tick,
    output logic [1:0] direction,
    output logic       dir_pending,
    output logic       dir_changed
);

    logic [3:0] syncIn;
    logic [1:0] xAxis;
    logic [1:0] yAxis;
    reqT        xReq;
    reqT        yReq;
    reqT        rawReq;
    reqT        stableReq;
    logic       stableChanged;
    dirT        pendDir;
    dirT        curDir;
    dirT        reqDir;
    logic       commit;
    logic       accept;

    joystick_direction_ctrl_debounce #(
        .SYNC_W          (4),
        .SYNC_INIT       ({AXIS_CENTRE, AXIS_CENTRE}),
        .REQ_W           (3),
        .REQ_INIT        (REQ_NONE),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) debounce (
        .clk           (clk),
        .reset         (reset),
        .asyncIn       ({res_x_one, res_x_two, res_y_one, res_y_two}),
        .syncOut       (syncIn),
        .rawReq        (rawReq),
        .stableReq     (stableReq),
        .stableChanged (stableChanged)
    );

    assign xAxis = syncIn[3:2];
    assign yAxis = syncIn[1:0];

    // Per-axis decode; centre and the invalid pattern both yield no request.
    always_comb begin
        xReq = REQ_NONE;
        yReq = REQ_NONE;
        if (xAxis == AXIS_POS)      xReq = dirReq(DIR_RIGHT);
        else if (xAxis == AXIS_NEG) xReq = dirReq(DIR_LEFT);
        if (yAxis == AXIS_POS)      yReq = dirReq(DIR_UP);
        else if (yAxis == AXIS_NEG) yReq = dirReq(DIR_DOWN);
    end

    // With a diagonal stick the axis perpendicular to travel is the only one
    // that can be a turn, so it takes priority.
    always_comb begin
        rawReq = yReq;
        if (xReq != REQ_NONE && yReq != REQ_NONE) begin
            rawReq = isHorizontal(direction) ? yReq : xReq;
        end else if (xReq != REQ_NONE) begin
            rawReq = xReq;
        end
    end

    // A commit and an acceptance may coincide; the new request is then judged
    // against the direction that is being committed in this same edge.
    assign commit = move_tick && dir_pending;
    assign curDir = commit ? pendDir : direction;
    assign reqDir = stableReq[1:0];
    assign accept = stableChanged && (stableReq != REQ_NONE)
                 && (reqDir != curDir) && (reqDir != reverseDir(curDir));

    // NOTE: pendDir is only meaningful while dir_pending is set, but it is reset
    // anyway so the register never carries X into curDir.
    always_ff @(posedge clk) begin
        if (reset) begin
            direction   <= INIT_DIR;
            pendDir     <= INIT_DIR;
            dir_pending <= 1'b0;
            dir_changed <= 1'b0;
        end else begin
            dir_changed <= commit;
            if (commit) begin
                direction <= pendDir;
            end
            if (accept) begin
                pendDir     <= reqDir;
                dir_pending <= 1'b1;
            end else if (commit) begin
                dir_pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_joystick_direction_ctrl.sv
// -----------------------------------------------------------------------------
// tb_joystick_direction_ctrl
// Directed bench for joystick_direction_ctrl with DEBOUNCE_CYCLES=4, so a held
// stick raises dir_pending 7 edges after the inputs change.
// -----------------------------------------------------------------------------
module tb_joystick_direction_ctrl;

    localparam logic [1:0] NEG = 2'b00;
    localparam logic [1:0] CEN = 2'b10;
    localparam logic [1:0] POS = 2'b11;
    localparam logic [1:0] INV = 2'b01;

    logic       clk = 1'b0;
    logic       reset;
    logic       res_x_one;
    logic       res_x_two;
    logic       res_y_one;
    logic       res_y_two;
    logic       move_tick;
    logic [1:0] direction;
    logic       dir_pending;
    logic       dir_changed;

    int testsRun    = 0;
    int testsFailed = 0;

    joystick_direction_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (3),
        .INIT_DIR        (2'd1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .res_x_one   (res_x_one),
        .res_x_two   (res_x_two),
        .res_y_one   (res_y_one),
        .res_y_two   (res_y_two),
        .move_tick   (move_tick),
        .direction   (direction),
        .dir_pending (dir_pending),
        .dir_changed (dir_changed)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic setStick(input logic [1:0] x, input logic [1:0] y);
        {res_x_one, res_x_two} = x;
        {res_y_one, res_y_two} = y;
    endtask

    task automatic doReset();
        reset     = 1'b1;
        move_tick = 1'b0;
        setStick(CEN, CEN);
        step(1);
        reset = 1'b0;
    endtask

    task automatic tick();
        move_tick = 1'b1;
        step(1);
        move_tick = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        move_tick = 1'b0;
        setStick(CEN, CEN);
        step(2);

        // 1: UP request, exact latency, commit on tick
        doReset();
        check("rst_dir", direction, 1);
        check("rst_pend", dir_pending, 0);
        check("rst_chg", dir_changed, 0);
        setStick(CEN, POS);
        step(6);
        check("t1_pend_c6", dir_pending, 0);
        step(1);
        check("t1_pend_c7", dir_pending, 1);
        check("t1_dir_c7", direction, 1);
        step(3);
        check("t1_pend_c10", dir_pending, 1);
        check("t1_dir_c10", direction, 1);
        tick();
        check("t1_dir_tick", direction, 0);
        check("t1_chg_tick", dir_changed, 1);
        check("t1_pend_tick", dir_pending, 0);
        step(1);
        check("t1_chg_after", dir_changed, 0);
        check("t1_dir_after", direction, 0);

        // 2: reversal ignored, tick without pending turn
        doReset();
        setStick(NEG, CEN);
        step(10);
        check("t2_pend", dir_pending, 0);
        tick();
        check("t2_dir", direction, 1);
        check("t2_chg", dir_changed, 0);

        // 3: bouncing X never saturates; bouncing Y must not leave a stale accept
        doReset();
        for (int i = 0; i < 10; i++) begin
            setStick((i % 2 == 0) ? POS : NEG, CEN);
            step(3);
        end
        check("t3_x_pend", dir_pending, 0);
        check("t3_x_dir", direction, 1);
        for (int i = 0; i < 10; i++) begin
            setStick(CEN, (i % 2 == 0) ? POS : NEG);
            step(3);
        end
        check("t3_y_pend", dir_pending, 0);
        setStick(CEN, POS);
        step(6);
        check("t3_hold_c6", dir_pending, 0);
        step(1);
        check("t3_hold_c7", dir_pending, 1);

        // 4: newer accepted turn overwrites the older one
        doReset();
        setStick(CEN, POS);
        step(7);
        check("t4_up_pend", dir_pending, 1);
        setStick(CEN, NEG);
        step(7);
        check("t4_down_pend", dir_pending, 1);
        tick();
        check("t4_dir", direction, 2);
        check("t4_chg", dir_changed, 1);

        // 5a: tick coincides with acceptance of LEFT, legal after UP commits
        doReset();
        setStick(CEN, POS);
        step(7);
        setStick(NEG, CEN);
        step(6);
        tick();
        check("t5a_dir", direction, 0);
        check("t5a_chg", dir_changed, 1);
        check("t5a_pend", dir_pending, 1);
        tick();
        check("t5a_dir2", direction, 3);
        check("t5a_pend2", dir_pending, 0);

        // 5b: tick coincides with DOWN, which reverses the just-committed UP
        doReset();
        setStick(CEN, POS);
        step(7);
        setStick(CEN, NEG);
        step(6);
        tick();
        check("t5b_dir", direction, 0);
        check("t5b_pend", dir_pending, 0);

        // Diagonal stick: perpendicular axis wins
        doReset();
        setStick(POS, POS);
        step(7);
        check("diag_up_pend", dir_pending, 1);
        tick();
        check("diag_up_dir", direction, 0);
        setStick(NEG, POS);
        step(7);
        check("diag_left_pend", dir_pending, 1);
        tick();
        check("diag_left_dir", direction, 3);

        // 6: reset mid-debounce with a turn pending, then invalid patterns
        doReset();
        setStick(CEN, POS);
        step(7);
        check("t6_pend_pre", dir_pending, 1);
        setStick(CEN, NEG);
        step(5);
        reset = 1'b1;
        setStick(INV, INV);
        step(1);
        reset = 1'b0;
        check("t6_dir", direction, 1);
        check("t6_pend", dir_pending, 0);
        check("t6_chg", dir_changed, 0);
        step(12);
        check("t6_inv_pend", dir_pending, 0);
        tick();
        check("t6_inv_dir", direction, 1);
        check("t6_inv_chg", dir_changed, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
